// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch-side, data-side and memory-side signals
// of the memory arbiter. The "slave" modport is the arbiter's view; the
// "master" modport is the view of the pipeline stages plus the memory macro.
//
// Handshake (both requesters): req rises with addr/wr/wdata valid and stays
// high until the matching done pulses for one cycle; rdata is valid in the
// done cycle and holds until the next read of that side completes. Stall is
// the combinational req & ~done. The memory port is a one-cycle issue pulse
// (mem_en) with read data returned a fixed number of cycles later.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // fetch side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          if_stall;
  // data side
  logic          dm_req;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_done;
  logic          dm_err;
  logic          dm_stall;
  // memory side
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  // dump forwarding, status and FSM observation
  logic          dmp;
  logic          mem_dump;
  logic          busy;
  logic [1:0]    fsm_state;

  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, dmp,
    output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_err, dm_stall,
    output mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, busy, fsm_state
  );

  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, dmp,
    input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_err, dm_stall,
    input  mem_en, mem_wr, mem_addr, mem_wdata, mem_dump, busy, fsm_state
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, fixed-latency memory between the
// instruction-fetch (IF) and memory-stage (DM) requesters. One transaction is
// in flight at a time: IDLE -> ISSUE -> WAIT -> DONE, giving LATENCY+2 cycles
// from the first req cycle to done. Misaligned DM accesses skip the memory and
// complete in one cycle with dm_err.
// Build macro MEM_ARB_RR_EN: round-robin on conflict (history bit, DM first
// after reset). Without it, DM always wins a conflict.
// The FSM state is visible on bus.fsm_state (IDLE=0, ISSUE=1, WAIT=2, DONE=3).
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // WAIT runs while the counter steps from LATENCY-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_dm;      // winner id: 1 = DM, 0 = IF
  logic          lat_wr;      // latched write flag of the winner

  logic          mem_en_q;
  logic          mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] dm_rdata_q;
  logic          if_done_q;
  logic          dm_done_q;
  logic          dm_err_q;
  logic          mem_dump_q;

  logic          any_req;
  logic          grant_dm;
  logic          win_wr;
  logic          misaligned;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

`ifdef MEM_ARB_RR_EN
  logic          last_dm;     // 1 when the most recent grant went to DM
`endif

  // Arbitration: pick the winner among the requests seen in IDLE.
  always_comb begin
    any_req = bus.if_req | bus.dm_req;
`ifdef MEM_ARB_RR_EN
    grant_dm = bus.dm_req & (~bus.if_req | ~last_dm);
`else
    grant_dm = bus.dm_req;
`endif
    win_addr   = grant_dm ? bus.dm_addr : bus.if_addr;
    win_wdata  = grant_dm ? bus.dm_wdata : '0;
    win_wr     = grant_dm & bus.dm_wr;
    misaligned = grant_dm & bus.dm_addr[0];
  end

  // Transaction sequencer with registered memory-port and completion outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_dm      <= 1'b0;
      lat_wr      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      dm_err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            lat_dm <= grant_dm;
            lat_wr <= win_wr;
            if (misaligned) begin
              // No memory access: report the error right away.
              dm_done_q <= 1'b1;
              dm_err_q  <= 1'b1;
              state     <= DONE;
            end else begin
              // Latched values go straight onto the memory port so they are
              // present during the ISSUE cycle and held through WAIT.
              mem_en_q    <= 1'b1;
              mem_wr_q    <= win_wr;
              mem_addr_q  <= win_addr;
              mem_wdata_q <= win_wdata;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_en_q <= 1'b0;
          mem_wr_q <= 1'b0;
          cnt      <= CNT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (!lat_wr) begin
              if (lat_dm) dm_rdata_q <= bus.mem_rdata;
              else        if_rdata_q <= bus.mem_rdata;
            end
            if (lat_dm) dm_done_q <= 1'b1;
            else        if_done_q <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if_done_q <= 1'b0;
          dm_done_q <= 1'b0;
          dm_err_q  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Grant history: remembers which side won the latest grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_dm <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_dm <= grant_dm;
    end
  end
`endif

  // Dump request is only delayed by one flop, independent of the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_dump_q <= 1'b0;
    else      mem_dump_q <= bus.dmp;
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.mem_dump  = mem_dump_q;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;
  assign bus.if_stall  = bus.if_req & ~if_done_q;
  assign bus.dm_stall  = bus.dm_req & ~dm_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table of single transactions plus hand-written sequences for
// conflict, dropped request, dump forwarding, round-robin (when built with
// MEM_ARB_RR_EN) and reset in the middle of a read. A behavioural memory with
// LAT-cycle read latency sits on the memory port; expected completions are
// queued when a request is raised and compared when done pulses.
module tb_mem_arbiter;
  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int SW  = 3 + 2 * DW;  // {if_done, dm_done, dm_err, if_rdata, dm_rdata}

  typedef struct {
    logic          dm;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rd;    // winner's rdata at done (held value for writes)
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_push = 0;
  int   en_count = 0;
  int   wr_count = 0;
  int   done_count = 0;
  int   en_cyc = 0;

  logic [SW-1:0] exp_q[$];
  logic [DW-1:0] m_if = '0;
  logic [DW-1:0] m_dm = '0;
  bit            m_last_dm = 1'b0;

  vec_t vecs[12];

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_arbiter #(.LATENCY(LAT), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, still running, required finished");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [DW-1:0] mem_arr [0:255];
  logic [DW-1:0] rd_pipe [0:LAT-1];
  bit            rd_vld  [0:LAT-1];

  function automatic logic [DW-1:0] init_word(input logic [7:0] a);
    return (a == 8'h10) ? 16'h1234 : {8'hA5, a};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(8'(i));
      for (int i = 0; i < LAT; i++) begin
        rd_pipe[i] <= '0;
        rd_vld[i]  <= 1'b0;
      end
    end else begin
      if (bus.mem_en && bus.mem_wr) mem_arr[bus.mem_addr[7:0]] <= bus.mem_wdata;
      rd_pipe[0] <= mem_arr[bus.mem_addr[7:0]];
      rd_vld[0]  <= bus.mem_en && !bus.mem_wr;
      for (int i = 1; i < LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
        rd_vld[i]  <= rd_vld[i-1];
      end
    end
  end
  assign bus.mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 16'hDEAD;

  // ---------------- port activity monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (bus.mem_en) begin
        en_count <= en_count + 1;
        en_cyc   <= cyc;
      end
      if (bus.mem_en && bus.mem_wr) wr_count <= wr_count + 1;
      if (bus.if_done || bus.dm_done) done_count <= done_count + 1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic void push_exp(input bit dm, input bit err, input logic [DW-1:0] rd);
    if (dm) m_dm = rd;
    else    m_if = rd;
    exp_q.push_back({~dm, dm, err, m_if, m_dm});
    n_push++;
    m_last_dm = dm;
  endfunction

  task automatic sb_pop(input string tag);
    logic [SW-1:0] got;
    logic [SW-1:0] exp;
    got = {bus.if_done, bus.dm_done, bus.dm_err, bus.if_rdata, bus.dm_rdata};
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: got %0h with nothing expected", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_sb"}, 128'(got), 128'(exp));
    end
  endtask

  function automatic logic [127:0] outs_now();
    return 128'({bus.if_rdata, bus.if_done, bus.if_stall, bus.dm_rdata, bus.dm_done,
                 bus.dm_err, bus.dm_stall, bus.mem_en, bus.mem_wr, bus.mem_addr,
                 bus.mem_wdata, bus.mem_dump, bus.busy, bus.fsm_state});
  endfunction

  // ---------------- driver ----------------
  // Called on a falling edge: raises req (that cycle is cycle 0), waits for
  // done, checks latency, stall and the queued completion, then drops req.
  task automatic txn(input bit dm, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input int exp_k,
                     input bit scramble, input string tag);
    int k;
    bit stall_ok;
    bit done;
    if (dm) begin
      bus.dm_wr    = wr;
      bus.dm_addr  = addr;
      bus.dm_wdata = wdata;
      bus.dm_req   = 1'b1;
    end else begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end
    #1;
    stall_ok = dm ? bus.dm_stall : bus.if_stall;
    k = 0;
    done = 1'b0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
      done = dm ? bus.dm_done : bus.if_done;
      if (!done) begin
        if (!(dm ? bus.dm_stall : bus.if_stall)) stall_ok = 1'b0;
        if (scramble && k == 2) begin
          if (dm) begin
            bus.dm_addr  = AW'($urandom_range(32'hFFFF, 0));
            bus.dm_wdata = DW'($urandom_range(32'hFFFF, 0));
          end else begin
            bus.if_addr = AW'($urandom_range(32'hFFFF, 0));
          end
        end
      end
    end
    check({tag, "_lat"}, 128'(k), 128'(exp_k));
    if (done) begin
      if (dm ? bus.dm_stall : bus.if_stall) stall_ok = 1'b0;
      check({tag, "_stall"}, 128'(stall_ok), 128'(1));
      sb_pop(tag);
    end
    if (dm) bus.dm_req = 1'b0;
    else    bus.if_req = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic [DW-1:0] rnd;
    bit mis;
    bit first_dm;
    int e0, w0, s0, k, kd, ki;

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_wr = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.dmp = 1'b0;
    rnd = DW'($urandom_range(32'hFFFF, 0));

    //              dm    wr    addr      wdata     err   rd (winner, at done)
    vecs[0]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
    vecs[1]  = '{1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
    vecs[3]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b1, 16'h0031, 16'h1111, 1'b1, 16'hBEEF};
    vecs[6]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, 16'hA530};
    vecs[7]  = '{1'b0, 1'b0, 16'h0031, 16'h0000, 1'b0, 16'hA531};
    vecs[8]  = '{1'b1, 1'b1, 16'h0050, rnd,      1'b0, 16'hA530};
    vecs[9]  = '{1'b1, 1'b0, 16'h0050, 16'h0000, 1'b0, rnd};
    vecs[10] = '{1'b0, 1'b0, 16'h0050, 16'h0000, 1'b0, rnd};
    vecs[11] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};

    // reset state
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check("reset_outs", outs_now(), 128'(0));
    @(negedge clk);
    rst = 1'b1;

    // single transactions from the table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_idle", i), 128'({bus.busy, bus.fsm_state}), 128'(0));
      mis = vecs[i].dm & vecs[i].addr[0];
      e0 = en_count;
      w0 = wr_count;
      s0 = cyc;
      push_exp(vecs[i].dm, vecs[i].err, vecs[i].rd);
      txn(vecs[i].dm, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
          mis ? 1 : LAT + 2, 1'b1, $sformatf("v%0d", i));
      check($sformatf("v%0d_en", i), 128'(en_count - e0), 128'(mis ? 0 : 1));
      check($sformatf("v%0d_wr", i), 128'(wr_count - w0),
            128'((!mis && vecs[i].dm && vecs[i].wr) ? 1 : 0));
      if (!mis) check($sformatf("v%0d_en_cyc", i), 128'(en_cyc), 128'(s0 + 1));
    end

    // conflict: both requests rise together
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    first_dm = !m_last_dm;
`else
    first_dm = 1'b1;
`endif
    if (first_dm) begin
      push_exp(1'b1, 1'b0, 16'hA530);
      push_exp(1'b0, 1'b0, 16'h1234);
    end else begin
      push_exp(1'b0, 1'b0, 16'h1234);
      push_exp(1'b1, 1'b0, 16'hA530);
    end
    fork
      txn(1'b1, 1'b0, 16'h0030, 16'h0000, first_dm ? LAT + 2 : 2 * LAT + 5, 1'b0, "cf_dm");
      txn(1'b0, 1'b0, 16'h0010, 16'h0000, first_dm ? 2 * LAT + 5 : LAT + 2, 1'b0, "cf_if");
    join

    // dropped DM request, fetch arrives while DM is in flight
    @(negedge clk);
    push_exp(1'b1, 1'b0, 16'hBEEF);
    push_exp(1'b0, 1'b0, 16'hA542);
    bus.dm_wr = 1'b0; bus.dm_addr = 16'h0020; bus.dm_req = 1'b1;
    k = 0; kd = -1; ki = -1;
    while (ki < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        bus.dm_req  = 1'b0;
        bus.if_addr = 16'h0042;
        bus.if_req  = 1'b1;
      end
      if (bus.dm_done) begin
        kd = k;
        sb_pop("drop_dm");
      end
      if (bus.if_done) begin
        ki = k;
        sb_pop("drop_if");
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0;
    check("drop_dm_lat", 128'(kd), 128'(LAT + 2));
    check("drop_if_lat", 128'(ki), 128'(2 * LAT + 5));

    // dump forwarding through one flop
    @(negedge clk);
    bus.dmp = 1'b1;
    #1 check("dump_pre", 128'(bus.mem_dump), 128'(0));
    @(negedge clk);
    check("dump_set", 128'(bus.mem_dump), 128'(1));
    bus.dmp = 1'b0;
    @(negedge clk);
    check("dump_clr", 128'(bus.mem_dump), 128'(0));

`ifdef MEM_ARB_RR_EN
    // persistent conflict: grants alternate between the two sides
    @(negedge clk);
    first_dm = !m_last_dm;
    repeat (2) begin
      push_exp(first_dm, 1'b0, first_dm ? 16'hBEEF : 16'h1234);
      push_exp(!first_dm, 1'b0, first_dm ? 16'h1234 : 16'hBEEF);
    end
    fork
      begin
        txn(first_dm, 1'b0, first_dm ? 16'h0020 : 16'h0010, 16'h0000, LAT + 2, 1'b0, "rr_a0");
        @(negedge clk);
        txn(first_dm, 1'b0, first_dm ? 16'h0020 : 16'h0010, 16'h0000, 2 * LAT + 5, 1'b0, "rr_a1");
      end
      begin
        txn(!first_dm, 1'b0, first_dm ? 16'h0010 : 16'h0020, 16'h0000, 2 * LAT + 5, 1'b0, "rr_b0");
        @(negedge clk);
        txn(!first_dm, 1'b0, first_dm ? 16'h0010 : 16'h0020, 16'h0000, 2 * LAT + 5, 1'b0, "rr_b1");
      end
    join
`endif

    // reset in the middle of a read, then a normal read
    @(negedge clk);
    bus.if_addr = 16'h0010;
    bus.if_req  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus.if_req = 1'b0;
    #1 check("rst_mid_outs", outs_now(), 128'(0));
    m_if = '0;
    m_dm = '0;
    m_last_dm = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_exp(1'b0, 1'b0, 16'hA512);
    txn(1'b0, 1'b0, 16'h0012, 16'h0000, LAT + 2, 1'b1, "post_rst");

    // every done accounted for
    repeat (2) @(negedge clk);
    check("done_total", 128'(done_count), 128'(n_push));
    check("queue_left", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
